// File: rtl/async_fifo_pkg.sv
// Shared constants and types for the single-clock FIFO slice.
// Default geometry lives here so the RTL and any user agree on one source.
package async_fifo_pkg;

   localparam int DEFAULT_DATA_WIDTH = 24;
   localparam int DEFAULT_DEPTH      = 8;
   localparam int DEFAULT_ADDR_WIDTH = $clog2(DEFAULT_DEPTH);

   typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

endpackage : async_fifo_pkg

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array with one synchronous write port and one
// synchronous, registered read port whose output register is cleared by rst.
module fifo_mem
   import async_fifo_pkg::*;
#(
   parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter  int DEPTH      = DEFAULT_DEPTH,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // NOTE: the storage array has no reset; stale words are unreachable once
   // the pointers are cleared, and leaving it out keeps it mappable to RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         // NOTE: non-blocking assignments in clocked blocks so every register
         // samples pre-edge values regardless of statement order.
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule : fifo_mem

// File: rtl/async_fifo.sv
// Single-clock 8x24 FIFO: wrap-bit pointers, accept logic and status flags
// around a fifo_mem array; read data is registered, no fall-through.
module async_fifo
   import async_fifo_pkg::*;
#(
   parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter  int DEPTH      = DEFAULT_DEPTH,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  w_enable,
   input  logic                  r_enable,
   input  logic [DATA_WIDTH-1:0] w_data,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic                  empty,
   output logic                  full
);

   localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [ADDR_WIDTH:0] wptr;
   logic [ADDR_WIDTH:0] rptr;
   logic                wr_accept;
   logic                rd_accept;
   logic                mem_we;
   logic                mem_re;

   // Equal pointers mean empty; same slot but opposite lap means full.
   assign empty = (wptr == rptr);
   assign full  = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                  (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);

   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch
      // is inferred.
      rd_accept = 1'b0;
      wr_accept = 1'b0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      rd_accept = r_enable && !empty;
      // A read on a full FIFO frees the slot the write lands in.
      wr_accept = w_enable && (!full || rd_accept);
      mem_we    = wr_accept && !rst;
      mem_re    = rd_accept;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_accept) begin
            wptr <= wptr + PTR_ONE;
         end
         if (rd_accept) begin
            rptr <= rptr + PTR_ONE;
         end
      end
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (mem_we),
      .waddr (wptr[ADDR_WIDTH-1:0]),
      .wdata (w_data),
      .re    (mem_re),
      .raddr (rptr[ADDR_WIDTH-1:0]),
      .rdata (r_data)
   );

endmodule : async_fifo

// File: tb/tb_async_fifo.sv
// Directed plus randomized bench for async_fifo, checked against a queue
// model of FIFO occupancy and the registered read word.
module tb_async_fifo;
   import async_fifo_pkg::*;

   localparam int DEPTH = DEFAULT_DEPTH;

   logic  clk = 1'b0;
   logic  rst;
   logic  w_enable;
   logic  r_enable;
   data_t w_data;
   data_t r_data;
   logic  empty;
   logic  full;

   int    total = 0;
   int    bad   = 0;

   data_t model_q[$];
   data_t model_rd = '0;

   async_fifo dut (
      .clk      (clk),
      .rst      (rst),
      .w_enable (w_enable),
      .r_enable (r_enable),
      .w_data   (w_data),
      .r_data   (r_data),
      .empty    (empty),
      .full     (full)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, advance the model at the edge, compare on the falling edge.
   task automatic step(input logic s_rst, input logic s_w, input logic s_r,
                       input data_t s_d, input string tag);
      bit rd_ok;
      bit wr_ok;
      rst      = s_rst;
      w_enable = s_w;
      r_enable = s_r;
      w_data   = s_d;
      @(posedge clk);
      if (s_rst) begin
         model_q.delete();
         model_rd = '0;
      end else begin
         rd_ok = s_r && (model_q.size() > 0);
         wr_ok = s_w && ((model_q.size() < DEPTH) || rd_ok);
         if (rd_ok) model_rd = model_q.pop_front();
         if (wr_ok) model_q.push_back(s_d);
      end
      @(negedge clk);
      rst      = 1'b0;
      w_enable = 1'b0;
      r_enable = 1'b0;
      check({tag, "_rdata"}, 32'(r_data), 32'(model_rd));
      check({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
      check({tag, "_full"},  32'(full),  32'(model_q.size() == DEPTH));
   endtask

   initial begin
      rst      = 1'b1;
      w_enable = 1'b0;
      r_enable = 1'b0;
      w_data   = '0;

      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, '0, "reset");
      check("reset_empty", 32'(empty), 32'd1);
      check("reset_full",  32'(full),  32'd0);
      check("reset_rdata", 32'(r_data), 32'h0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, data_t'(24'h5A5A5A), "idle");

      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, data_t'(i), "fill");
      check("fill_full",  32'(full),  32'd1);
      check("fill_empty", 32'(empty), 32'd0);
      step(1'b0, 1'b1, 1'b0, data_t'(24'h0000AA), "fill_drop");

      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 1'b0, 1'b1, '0, "drain");
         check("drain_order", 32'(r_data), 32'(i));
      end
      check("drain_empty", 32'(empty), 32'd1);
      step(1'b0, 1'b0, 1'b1, '0, "drain_extra");
      check("drain_hold", 32'(r_data), 32'h000007);

      for (int pass = 0; pass < 3; pass++) begin
         for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 1'b0, data_t'(24'h100000 + i), "wrap_fill");
            check("wrap_full_timing", 32'(full), 32'(i == DEPTH - 1));
         end
         for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b0, 1'b1, '0, "wrap_drain");
            check("wrap_order", 32'(r_data), 32'h100000 + 32'(i));
            check("wrap_empty_timing", 32'(empty), 32'(i == DEPTH - 1));
         end
      end

      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, data_t'(24'h200000 + i), "simul_prep");
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b1, 1'b1, data_t'(24'h300000 + i), "simul_half");
         check("simul_half_empty", 32'(empty), 32'd0);
         check("simul_half_full",  32'(full),  32'd0);
      end
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, data_t'(24'h400000 + i), "simul_top");
      check("simul_top_full", 32'(full), 32'd1);
      step(1'b0, 1'b1, 1'b1, data_t'(24'h4000FF), "simul_full");
      check("simul_full_stays", 32'(full), 32'd1);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, '0, "simul_drain");
      check("simul_drain_last", 32'(r_data), 32'h4000FF);
      step(1'b0, 1'b1, 1'b1, data_t'(24'h500000), "simul_empty");
      check("simul_empty_rdata", 32'(r_data), 32'h4000FF);
      check("simul_empty_flag",  32'(empty), 32'd0);
      step(1'b0, 1'b0, 1'b1, '0, "simul_empty_rd");
      check("simul_empty_word", 32'(r_data), 32'h500000);

      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, data_t'(24'h600000 + i), "mid_fill");
      step(1'b1, 1'b1, 1'b1, data_t'(24'h6000EE), "mid_reset");
      check("mid_reset_empty", 32'(empty), 32'd1);
      check("mid_reset_rdata", 32'(r_data), 32'h0);
      step(1'b0, 1'b1, 1'b0, data_t'(24'h00ABCD), "mid_write");
      step(1'b0, 1'b0, 1'b1, '0, "mid_read");
      check("mid_read_word", 32'(r_data), 32'h00ABCD);

      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), data_t'($urandom), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_async_fifo
